quad_counter: RTL and testbench



---
 rtl/quad_counter_if.sv | 24 ++
 rtl/quad_counter.sv | 185 ++++++++++++++++++
 tb/tb_quad_counter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_counter_if.sv
// quad_counter_if: encoder pins, clear request and decoded position outputs.
// Build option QUAD_INDEX_EN adds the idx (encoder Z) input.
interface quad_counter_if #(
  parameter int WIDTH = 16
);
  logic                    a;
  logic                    b;
  logic                    clear;
`ifdef QUAD_INDEX_EN
  logic                    idx;
`endif
  logic                    step;
  logic                    dir;
  logic signed [WIDTH-1:0] count;
  logic                    err;

`ifdef QUAD_INDEX_EN
  modport master (output a, b, clear, idx, input step, dir, count, err);
  modport slave  (input a, b, clear, idx, output step, dir, count, err);
`else
  modport master (output a, b, clear, input step, dir, count, err);
  modport slave  (input a, b, clear, output step, dir, count, err);
`endif
endinterface

// File: rtl/quad_counter.sv
// quad_counter: quadrature encoder front end. Synchronises and glitch-filters
// A/B, decodes at x1/x2/x4 resolution, keeps a signed position count and a
// sticky illegal-transition flag.
// Build option QUAD_INDEX_EN: idx input zeroes the count on a rising edge
// while filtered A=B=1.
module quad_counter #(
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 4,
  parameter int MODE       = 2,
  parameter int SATURATE   = 0
) (
  input logic           clk,
  input logic           rst,
  quad_counter_if.slave bus
);

  // Gray sequence position of {A,B}; counting up walks 00->10->11->01.
  typedef enum logic [1:0] {
    PH_00 = 2'd0,
    PH_10 = 2'd1,
    PH_11 = 2'd2,
    PH_01 = 2'd3
  } phase_e;

  localparam logic [8:0]       HOLD_CYCLES = 9'(FILTER_LEN + 3);
  localparam logic [WIDTH-1:0] CNT_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] CNT_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

  // Bit 1 carries channel A, bit 0 channel B.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [1:0]       prev;
  logic [8:0]       hold_cnt;
  logic             holdoff;
  logic             step_q;
  logic             dir_q;
  logic             err_q;
  logic [WIDTH-1:0] count_q;
  phase_e           cur_ph;
  phase_e           prv_ph;
  logic             changed;
  logic             illegal;
  logic             up;
  logic             counted;
  logic [WIDTH-1:0] count_nxt;
  logic             index_hit;

  function automatic phase_e phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_of = PH_00;
      2'b10:   phase_of = PH_10;
      2'b11:   phase_of = PH_11;
      default: phase_of = PH_01;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.a, bus.b};
      sync2 <= sync1;
    end
  end

  // Post-reset hold-off counter; decode is suppressed while it is non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= HOLD_CYCLES;
    end else if (holdoff) begin
      hold_cnt <= hold_cnt - 9'd1;
    end
  end

  assign holdoff = (hold_cnt != '0);

  if (FILTER_LEN == 0) begin : g_bypass
    assign filt = sync2;
  end else begin : g_filter
    logic [7:0] fcnt [2];

    // Per-channel stability filter: a new level must persist FILTER_LEN samples.
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (rst) begin
          fcnt[i] <= '0;
          filt[i] <= 1'b0;
        end else if (holdoff) begin
          fcnt[i] <= '0;
          filt[i] <= sync2[i];
        end else if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 8'(FILTER_LEN - 1)) begin
          fcnt[i] <= '0;
          filt[i] <= sync2[i];
        end else begin
          fcnt[i] <= fcnt[i] + 8'd1;
        end
      end
    end
  end

`ifdef QUAD_INDEX_EN
  logic idx_s1;
  logic idx_s2;
  logic idx_d;

  // Index pin synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_s1 <= 1'b0;
      idx_s2 <= 1'b0;
      idx_d  <= 1'b0;
    end else begin
      idx_s1 <= bus.idx;
      idx_s2 <= idx_s1;
      idx_d  <= idx_s2;
    end
  end

  assign index_hit = !holdoff && idx_s2 && !idx_d && (filt == 2'b11);
`else
  assign index_hit = 1'b0;
`endif

  // Transition classification and next count value.
  always_comb begin
    cur_ph    = phase_of(filt);
    prv_ph    = phase_of(prev);
    changed   = (filt != prev);
    illegal   = &(filt ^ prev);
    up        = (cur_ph == phase_e'(prv_ph + 2'd1));
    counted   = 1'b0;
    count_nxt = count_q;
    case (MODE)
      0:       counted = changed && !illegal && !prev[0] && !filt[0];
      1:       counted = changed && !illegal && (prev[1] != filt[1]);
      default: counted = changed && !illegal;
    endcase
    if (up) begin
      if (SATURATE != 0 && count_q == CNT_MAX) count_nxt = count_q;
      else                                     count_nxt = count_q + CNT_ONE;
    end else begin
      if (SATURATE != 0 && count_q == CNT_MIN) count_nxt = count_q;
      else                                     count_nxt = count_q - CNT_ONE;
    end
  end

  // Registered decode outputs. clear and index only override the count;
  // step/dir still report the transition seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      step_q <= 1'b0;
      prev   <= holdoff ? sync2 : filt;
      if (!holdoff && counted) begin
        step_q <= 1'b1;
        dir_q  <= up;
      end
      if (bus.clear) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (!holdoff) begin
        if (illegal)        err_q   <= 1'b1;
        if (index_hit)      count_q <= '0;
        else if (counted)   count_q <= count_nxt;
      end
    end
  end

  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.err   = err_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_quad_counter.sv
// tb_quad_counter: five quad_counter instances (x1, x2, x4, and two 4-bit x4
// variants wrapping/saturating) share one randomised A/B stimulus and are
// compared against a phase-level reference model.
`timescale 1ns/1ps
module tb_quad_counter;
  localparam int N  = 5;
  localparam int FL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a;
  logic b;
  logic clear;
`ifdef QUAD_INDEX_EN
  logic idx;
`endif

  int vectors     = 0;
  int miscompares = 0;

  int cfg_mode  [N] = '{0, 1, 2, 2, 2};
  int cfg_width [N] = '{16, 16, 16, 4, 4};
  int cfg_sat   [N] = '{0, 0, 0, 0, 1};
  int m_count   [N];
  int m_dir     [N];
  int m_steps   [N];
  int nsteps    [N];
  int m_err;
  int phase;

  quad_counter_if #(.WIDTH(16)) q0();
  quad_counter_if #(.WIDTH(16)) q1();
  quad_counter_if #(.WIDTH(16)) q2();
  quad_counter_if #(.WIDTH(4))  q3();
  quad_counter_if #(.WIDTH(4))  q4();

  assign q0.a = a;  assign q0.b = b;  assign q0.clear = clear;
  assign q1.a = a;  assign q1.b = b;  assign q1.clear = clear;
  assign q2.a = a;  assign q2.b = b;  assign q2.clear = clear;
  assign q3.a = a;  assign q3.b = b;  assign q3.clear = clear;
  assign q4.a = a;  assign q4.b = b;  assign q4.clear = clear;
`ifdef QUAD_INDEX_EN
  assign q0.idx = idx; assign q1.idx = idx; assign q2.idx = idx;
  assign q3.idx = idx; assign q4.idx = idx;
`endif

  quad_counter #(.WIDTH(16), .FILTER_LEN(FL), .MODE(0), .SATURATE(0)) u_x1
    (.clk(clk), .rst(rst), .bus(q0));
  quad_counter #(.WIDTH(16), .FILTER_LEN(FL), .MODE(1), .SATURATE(0)) u_x2
    (.clk(clk), .rst(rst), .bus(q1));
  quad_counter #(.WIDTH(16), .FILTER_LEN(FL), .MODE(2), .SATURATE(0)) u_x4
    (.clk(clk), .rst(rst), .bus(q2));
  quad_counter #(.WIDTH(4),  .FILTER_LEN(FL), .MODE(2), .SATURATE(0)) u_w4
    (.clk(clk), .rst(rst), .bus(q3));
  quad_counter #(.WIDTH(4),  .FILTER_LEN(FL), .MODE(2), .SATURATE(1)) u_s4
    (.clk(clk), .rst(rst), .bus(q4));

  // Count step pulses per instance.
  always @(negedge clk) begin
    if (q0.step) nsteps[0] = nsteps[0] + 1;
    if (q1.step) nsteps[1] = nsteps[1] + 1;
    if (q2.step) nsteps[2] = nsteps[2] + 1;
    if (q3.step) nsteps[3] = nsteps[3] + 1;
    if (q4.step) nsteps[4] = nsteps[4] + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int i, output int c, output int d, output int e);
    case (i)
      0:       begin c = int'(q0.count); d = int'(q0.dir); e = int'(q0.err); end
      1:       begin c = int'(q1.count); d = int'(q1.dir); e = int'(q1.err); end
      2:       begin c = int'(q2.count); d = int'(q2.dir); e = int'(q2.err); end
      3:       begin c = int'(q3.count); d = int'(q3.dir); e = int'(q3.err); end
      default: begin c = int'(q4.count); d = int'(q4.dir); e = int'(q4.err); end
    endcase
  endtask

  task automatic check_all(input string where);
    int c, d, e;
    #2;
    for (int i = 0; i < N; i++) begin
      get_obs(i, c, d, e);
      check($sformatf("%s/u%0d/count", where, i), c, m_count[i]);
      check($sformatf("%s/u%0d/dir", where, i), d, m_dir[i]);
      check($sformatf("%s/u%0d/err", where, i), e, m_err);
      check($sformatf("%s/u%0d/steps", where, i), nsteps[i], m_steps[i]);
    end
  endtask

  // Reference: position arithmetic on a signed range of the instance width.
  function automatic void model_add(input int i, input int delta);
    int v, hi, lo;
    hi = (1 << (cfg_width[i] - 1)) - 1;
    lo = -(1 << (cfg_width[i] - 1));
    v  = m_count[i] + delta;
    if (v > hi) v = (cfg_sat[i] != 0) ? hi : lo;
    if (v < lo) v = (cfg_sat[i] != 0) ? lo : hi;
    m_count[i] = v;
  endfunction

  // Reference: phase 0..3 = AB 00,10,11,01. A move of +1 is up, -1 down,
  // 2 is illegal. x2 counts edges whose lower phase is even, x1 only 0<->1.
  function automatic void model_move(input int to);
    int diff, lower;
    bit up, hit;
    diff = (to - phase) & 3;
    if (diff == 2) begin
      m_err = 1;
    end else if (diff != 0) begin
      up    = (diff == 1);
      lower = up ? phase : to;
      for (int i = 0; i < N; i++) begin
        hit = (cfg_mode[i] == 2) || (cfg_mode[i] == 1 && lower % 2 == 0) ||
              (cfg_mode[i] == 0 && lower == 0);
        if (hit) begin
          m_steps[i]++;
          m_dir[i] = up ? 1 : 0;
          model_add(i, up ? 1 : -1);
        end
      end
    end
    phase = to;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_count[i] = 0;
    m_err = 0;
  endfunction

  task automatic drive_phase(input int to);
    a = (to == 1 || to == 2);
    b = (to >= 2);
    model_move(to);
  endtask

  task automatic move_hold(input int to, input int hold);
    drive_phase(to);
    repeat (hold) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
  endtask

  task automatic glitch(input int ch, input int g);
    if (ch == 0) a = ~a; else b = ~b;
    repeat (g) @(negedge clk);
    if (ch == 0) a = ~a; else b = ~b;
    repeat (10) @(negedge clk);
  endtask

`ifdef QUAD_INDEX_EN
  task automatic pulse_idx();
    idx = 1'b1;
    repeat (4) @(negedge clk);
    idx = 1'b0;
    repeat (8) @(negedge clk);
    if (phase == 2) for (int i = 0; i < N; i++) m_count[i] = 0;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int early, r, n;
    rst   = 1'b1;
    clear = 1'b0;
    a     = 1'b1;
    b     = 1'b1;
`ifdef QUAD_INDEX_EN
    idx   = 1'b0;
`endif
    phase = 2;
    m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_count[i] = 0; m_dir[i] = 0; m_steps[i] = 0; nsteps[i] = 0;
    end

    repeat (3) @(negedge clk);
    check("rst/count", int'(q2.count), 0);
    check("rst/step", int'(q2.step), 0);
    check("rst/dir", int'(q2.dir), 0);
    check("rst/err", int'(q2.err), 0);
    rst = 1'b0;

    // Static 11 across the hold-off window: no error, no steps.
    repeat (20) @(negedge clk);
    check_all("static11");

    // Latency: A falls (11 -> 01, up); step must appear exactly at edge 7.
    drive_phase(3);
    early = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k < 7) early = early | int'(q2.step);
      else       check("latency/edge7", int'(q2.step), 1);
    end
    check("latency/early", early, 0);
    repeat (6) @(negedge clk);
    check_all("latency");

    // 3-cycle glitches on each channel are rejected.
    glitch(0, 3);
    check_all("glitchA");
    glitch(1, 3);
    check_all("glitchB");

    // From zero: 8 ups then 8 downs; 4-bit instances wrap / saturate.
    pulse_clear();
    for (int k = 0; k < 8; k++) move_hold((phase + 1) & 3, 10);
    check_all("up8");
    check("up8/x4", int'(q2.count), 8);
    check("up8/w4wrap", int'(q3.count), -8);
    check("up8/s4sat", int'(q4.count), 7);
    check("up8/dir", int'(q2.dir), 1);
    for (int k = 0; k < 8; k++) move_hold((phase + 3) & 3, 10);
    check_all("down8");
    check("down8/x4", int'(q2.count), 0);
    check("down8/dir", int'(q2.dir), 0);

    // Illegal double transition is sticky until clear.
    move_hold((phase + 2) & 3, 12);
    check_all("illegal");
    check("illegal/err", int'(q2.err), 1);
    move_hold((phase + 1) & 3, 12);
    check_all("illegal_sticky");
    pulse_clear();
    check_all("clear");

    // clear on the same edge as a counted transition wins over the count.
    move_hold((phase + 1) & 3, 10);
    drive_phase((phase + 1) & 3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    repeat (8) @(negedge clk);
    check_all("clear_vs_step");

    // Reset mid-operation.
    move_hold((phase + 1) & 3, 10);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst/count", int'(q2.count), 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin m_count[i] = 0; m_dir[i] = 0; end
    m_err = 0;
    repeat (20) @(negedge clk);
    check_all("midrst");

`ifdef QUAD_INDEX_EN
    while (phase != 2) move_hold((phase + 1) & 3, 10);
    pulse_idx();
    check_all("index");
    check("index/x4", int'(q2.count), 0);
`endif

    // Randomised operations.
    for (int op = 0; op < 150; op++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++)
          move_hold(($urandom_range(0, 1) != 0) ? ((phase + 1) & 3) : ((phase + 3) & 3),
                    $urandom_range(5, 8));
        repeat (8) @(negedge clk);
      end else if (r < 68) begin
        move_hold((phase + 2) & 3, 12);
      end else if (r < 80) begin
        glitch($urandom_range(0, 1), $urandom_range(1, 3));
      end else if (r < 88) begin
        pulse_clear();
`ifdef QUAD_INDEX_EN
      end else if (r < 95) begin
        pulse_idx();
`endif
      end else begin
        move_hold((phase + 1) & 3, 12);
      end
      check_all($sformatf("rand%0d", op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
